// File: rtl/observer_pkg.sv
// rtl/observer_pkg.sv - shared constants and types for the observer sample sequencer
//
// Purpose : frame delimiters, sweep FSM state encoding and the tag-byte layout
//           used by observer_sampler and its testbench.
// Ports   : none (package).

package observer_pkg;

   // Frame delimiters wrapped around every sweep's payload.
   localparam logic [7:0] OBS_SOF = 8'hA5;
   localparam logic [7:0] OBS_EOF = 8'h0A;

   // Bit of the per-channel tag byte that marks a timed-out sample.
   localparam int TAG_FLAG_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_NEXT,
      ST_SEND,
      ST_DONE
   } obs_state_e;

endpackage

// File: rtl/observer_debounce.sv
// rtl/observer_debounce.sv - push-button synchroniser, debouncer and rising-edge pulse
//
// Purpose : brings the raw button into the clock domain, accepts a new level
//           only after DEBOUNCE consecutive samples that differ from the
//           current accepted level, and pulses o_rise for one cycle when the
//           accepted level goes 0 -> 1.
// Ports   : i_clk  - system clock
//           i_rst  - asynchronous active-high reset
//           i_btn  - raw asynchronous button, active-high
//           o_rise - one-cycle pulse on a debounced rising edge

module observer_debounce #(
   parameter int DEBOUNCE = 120_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_rise
);

   localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise_q, rise_d;

   always_comb begin
      sync_d  = {sync_q[0], i_btn};
      level_d = level_q;
      cnt_d   = cnt_q;
      // Any sample equal to the accepted level restarts the stability window.
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
         level_d = sync_q[1];
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      rise_d = !level_q && level_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

   assign o_rise = rise_q;

endmodule

// File: rtl/observer_sampler.sv
// rtl/observer_sampler.sv - multi-channel sensor sweep sequencer with framed byte output
//
// Purpose : on a debounced button press or a periodic tick, reads NUM_CH
//           sensor controllers in turn over req/ack, buffers the samples and
//           streams one framed packet to the UART transmitter.
// Ports   : i_clk, i_rst   - clock, asynchronous active-high reset
//           i_user_btn     - raw push-button trigger
//           i_auto_en      - enables periodic sweeps every PERIOD cycles
//           o_req / i_ack  - one-hot request, per-channel one-cycle ack
//           i_data         - channel k sample at [k*DATA_W +: DATA_W]
//           o_tx_data/o_tx_valid/i_tx_ready - byte stream to the UART
//           o_busy         - sweep or transmission in progress
//           o_timeout_cnt  - saturating count of channel timeouts

module observer_sampler
   import observer_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DATA_W   = 16,
   parameter int PERIOD   = 12_000_000,
   parameter int DEBOUNCE = 120_000,
   parameter int TIMEOUT  = 65_535
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_user_btn,
   input  logic                     i_auto_en,
   output logic [NUM_CH-1:0]        o_req,
   input  logic [NUM_CH-1:0]        i_ack,
   input  logic [NUM_CH*DATA_W-1:0] i_data,
   output logic [7:0]               o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic                     o_busy,
   output logic [7:0]               o_timeout_cnt
);

   localparam int NB        = DATA_W / 8;
   localparam int FRAME_LEN = 2 + NUM_CH * (1 + NB);
   localparam int IDX_W     = $clog2(FRAME_LEN + 1);
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int PER_W     = (PERIOD > 1) ? $clog2(PERIOD + 1) : 1;

   obs_state_e       state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [PER_W-1:0] per_q, per_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic [7:0]       tocnt_q, tocnt_d;
   logic [NUM_CH-1:0] req_q, req_d;
   logic             txv_q, txv_d;
   logic [7:0]       txd_q, txd_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DATA_W:0]  buf_q [NUM_CH];
   logic [DATA_W:0]  buf_d [NUM_CH];

   logic             btn_rise;
   logic             trig;
   logic             busy;
   logic [IDX_W-1:0] nxt_idx;
   logic [7:0]       nxt_byte;
   logic [DATA_W:0]  entry;
   int               body;
   int               k_sel;
   int               j_sel;

   observer_debounce #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debounce (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_btn (i_user_btn),
      .o_rise(btn_rise)
   );

   // Period counter: free-runs only while auto mode is enabled.
   always_comb begin
      per_d  = per_q;
      tick_d = 1'b0;
      if (!i_auto_en) begin
         per_d = '0;
      end else if (per_q == PER_W'(PERIOD - 1)) begin
         per_d  = '0;
         tick_d = 1'b1;
      end else begin
         per_d = per_q + 1'b1;
      end
   end

   // A simultaneous button edge and tick merge into a single trigger.
   assign trig = btn_rise | tick_q;
   assign busy = (state_q != ST_IDLE);

   // Byte that follows the one currently on the bus. Body bytes are laid out
   // per channel as a tag followed by the sample bytes, MSB first.
   always_comb begin
      nxt_idx  = idx_q + 1'b1;
      body     = 0;
      k_sel    = 0;
      j_sel    = 0;
      entry    = '0;
      nxt_byte = OBS_EOF;
      if (int'(nxt_idx) < FRAME_LEN - 1) begin
         body  = int'(nxt_idx) - 1;
         k_sel = body / (NB + 1);
         j_sel = body % (NB + 1);
         entry = buf_q[CH_W'(k_sel)];
         if (j_sel == 0) begin
            nxt_byte               = {5'b0, 3'(k_sel)};
            nxt_byte[TAG_FLAG_BIT] = entry[DATA_W];
         end else begin
            nxt_byte = entry[DATA_W - 8*j_sel +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      tmr_d   = tmr_q;
      pend_d  = pend_q;
      tocnt_d = tocnt_q;
      req_d   = '0;
      txv_d   = txv_q;
      txd_d   = txd_q;
      idx_d   = idx_q;
      buf_d   = buf_q;

      // Only one trigger is remembered per busy period.
      if (trig && busy) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (trig || pend_q) begin
               state_d = ST_REQ;
               ch_d    = '0;
               tmr_d   = '0;
               pend_d  = 1'b0;
            end
         end
         ST_REQ: begin
            // The first REQ cycle only raises the request; acks count once
            // the request is actually visible to the channel.
            if (req_q[ch_q]) begin
               if (i_ack[ch_q]) begin
                  buf_d[ch_q] = {1'b0, i_data[ch_q*DATA_W +: DATA_W]};
                  state_d     = ST_NEXT;
               end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                  buf_d[ch_q] = '1;
                  tocnt_d     = (tocnt_q == 8'hFF) ? tocnt_q : tocnt_q + 8'd1;
                  state_d     = ST_NEXT;
               end else begin
                  tmr_d       = tmr_q + 1'b1;
                  req_d[ch_q] = 1'b1;
               end
            end else begin
               req_d[ch_q] = 1'b1;
            end
         end
         ST_NEXT: begin
            if (ch_q == CH_W'(NUM_CH - 1)) begin
               state_d = ST_SEND;
               idx_d   = '0;
               txv_d   = 1'b1;
               txd_d   = OBS_SOF;
            end else begin
               ch_d    = ch_q + 1'b1;
               tmr_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_SEND: begin
            if (txv_q && i_tx_ready) begin
               if (int'(idx_q) == FRAME_LEN - 1) begin
                  txv_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = nxt_idx;
                  txd_d = nxt_byte;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         tmr_q   <= '0;
         per_q   <= '0;
         tick_q  <= 1'b0;
         pend_q  <= 1'b0;
         tocnt_q <= '0;
         req_q   <= '0;
         txv_q   <= 1'b0;
         txd_q   <= '0;
         idx_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         tmr_q   <= tmr_d;
         per_q   <= per_d;
         tick_q  <= tick_d;
         pend_q  <= pend_d;
         tocnt_q <= tocnt_d;
         req_q   <= req_d;
         txv_q   <= txv_d;
         txd_q   <= txd_d;
         idx_q   <= idx_d;
         for (int i = 0; i < NUM_CH; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign o_req         = req_q;
   assign o_tx_valid    = txv_q;
   assign o_tx_data     = txd_q;
   assign o_busy        = busy;
   assign o_timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_observer_sampler.sv
// tb/tb_observer_sampler.sv - directed self-checking bench for observer_sampler

module tb_observer_sampler;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_user_btn = 1'b0;
   logic        i_auto_en = 1'b0;
   logic [1:0]  o_req;
   logic [1:0]  i_ack = 2'b00;
   logic [31:0] i_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b1;
   logic        o_busy;
   logic [7:0]  o_timeout_cnt;

   always #5 i_clk = ~i_clk;

   observer_sampler #(
      .NUM_CH  (2),
      .DATA_W  (16),
      .PERIOD  (100),
      .DEBOUNCE(8),
      .TIMEOUT (16)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_user_btn   (i_user_btn),
      .i_auto_en    (i_auto_en),
      .o_req        (o_req),
      .i_ack        (i_ack),
      .i_data       (i_data),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_busy       (o_busy),
      .o_timeout_cnt(o_timeout_cnt)
   );

   int          vec = 0;
   int          err = 0;
   logic [7:0]  rx_q [$];
   logic [7:0]  exp_b [8];
   bit          ack_en [2] = '{1'b1, 1'b1};
   int          ack_dly [2] = '{3, 1};
   logic [15:0] ack_val [2] = '{16'h1234, 16'hBEEF};
   int          req_cnt [2] = '{0, 0};
   int          rdy_mode = 0;

   assign i_data = {ack_val[1], ack_val[0]};

   // Channel controller model and UART ready driver, updated on the falling edge.
   always @(negedge i_clk) begin
      for (int k = 0; k < 2; k++) begin
         if (o_req[k]) req_cnt[k] = req_cnt[k] + 1;
         else          req_cnt[k] = 0;
         i_ack[k] = ack_en[k] && o_req[k] && (req_cnt[k] == ack_dly[k]);
      end
      case (rdy_mode)
         0:       i_tx_ready = 1'b1;
         1:       i_tx_ready = 1'($urandom_range(0, 1));
         default: i_tx_ready = 1'b0;
      endcase
   end

   // Byte collector, stall-stability check and timing trackers.
   int         cyc = 0;
   bit         stall_hold = 0;
   logic [7:0] stall_data = 8'h00;
   bit         busy_prev = 0;
   bit         req0_prev = 0;
   bit         req1_prev = 0;
   int         busy_rise_q [$];
   int         last_busy_rise = 0;
   int         req_lat = -1;
   int         req1_run = 0;
   int         req1_last = 0;

   always @(negedge i_clk) begin
      #3;
      cyc++;
      if (i_rst) begin
         stall_hold = 0;
         busy_prev  = 0;
         req0_prev  = 0;
         req1_prev  = 0;
         req1_run   = 0;
      end else begin
         if (stall_hold) begin
            vec++;
            assert (o_tx_valid === 1'b1 && o_tx_data === stall_data)
            else begin
               err++;
               $error("FAIL stall_hold valid=%b data=%02h required valid=1 data=%02h",
                      o_tx_valid, o_tx_data, stall_data);
            end
         end
         if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) rx_q.push_back(o_tx_data);
         stall_hold = (o_tx_valid === 1'b1) && (i_tx_ready !== 1'b1);
         stall_data = o_tx_data;
         if (o_busy && !busy_prev) begin
            busy_rise_q.push_back(cyc);
            last_busy_rise = cyc;
         end
         if (o_req[0] && !req0_prev) req_lat = cyc - last_busy_rise;
         if (o_req[1]) req1_run++;
         else if (req1_prev) begin
            req1_last = req1_run;
            req1_run  = 0;
         end
         busy_prev = o_busy;
         req0_prev = o_req[0];
         req1_prev = o_req[1];
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge i_clk);
         #4;
      end
   endtask

   task automatic chk(input string tag, input int got, input int want);
      vec++;
      assert (got === want)
      else begin
         err++;
         $error("FAIL %s got=%0h required=%0h", tag, got, want);
      end
   endtask

   task automatic press_btn();
      i_user_btn = 1'b1;
      tick(14);
      i_user_btn = 1'b0;
      tick(14);
   endtask

   task automatic build_exp(input logic f0, input logic [15:0] d0,
                            input logic f1, input logic [15:0] d1);
      exp_b[0] = 8'hA5;
      exp_b[1] = {f0, 7'd0};
      exp_b[2] = d0[15:8];
      exp_b[3] = d0[7:0];
      exp_b[4] = {f1, 7'd1};
      exp_b[5] = d1[15:8];
      exp_b[6] = d1[7:0];
      exp_b[7] = 8'h0A;
   endtask

   task automatic check_frame(input string tag);
      int t = 0;
      while (rx_q.size() < 8 && t < 3000) begin
         tick(1);
         t++;
      end
      vec++;
      assert (rx_q.size() >= 8)
      else begin
         err++;
         $error("FAIL %s frame_len got=%0d bytes required=8", tag, rx_q.size());
      end
      if (rx_q.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            vec++;
            assert (rx_q[0] === exp_b[i])
            else begin
               err++;
               $error("FAIL %s byte%0d got=%02h required=%02h", tag, i, rx_q[0], exp_b[i]);
            end
            void'(rx_q.pop_front());
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (o_busy && t < 500) begin
         tick(1);
         t++;
      end
      chk({tag, "_idle"}, int'(o_busy), 0);
   endtask

   initial begin
      int t;
      int want;
      logic [15:0] v0;
      logic [15:0] v1;

      // Reset state
      tick(3);
      chk("rst_req", int'(o_req), 0);
      chk("rst_valid", int'(o_tx_valid), 0);
      chk("rst_data", int'(o_tx_data), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_tocnt", int'(o_timeout_cnt), 0);
      i_rst = 1'b0;
      tick(3);

      // Glitchy button then stable press: exactly one frame
      for (int i = 0; i < 5; i++) begin
         i_user_btn = (i % 2 == 0);
         tick(1);
      end
      i_user_btn = 1'b1;
      tick(20);
      i_user_btn = 1'b0;
      tick(20);
      build_exp(1'b0, 16'h1234, 1'b0, 16'hBEEF);
      check_frame("t1");
      tick(60);
      chk("t1_one_frame", rx_q.size(), 0);
      chk("t1_tocnt", int'(o_timeout_cnt), 0);
      wait_idle("t1");

      // Channel 1 never acknowledges
      ack_en[1]  = 1'b0;
      ack_val[0] = 16'h5555;
      ack_dly[0] = 2;
      build_exp(1'b0, 16'h5555, 1'b1, 16'hFFFF);
      press_btn();
      check_frame("t2");
      chk("t2_tocnt", int'(o_timeout_cnt), 1);
      chk("t2_req1_len", req1_last, 16);
      wait_idle("t2");
      ack_en[1] = 1'b1;

      // Random backpressure over 50 frames
      rdy_mode = 1;
      for (int f = 0; f < 50; f++) begin
         v0 = 16'($urandom);
         v1 = 16'($urandom);
         ack_val[0] = v0;
         ack_val[1] = v1;
         ack_dly[0] = $urandom_range(1, 4);
         ack_dly[1] = $urandom_range(1, 4);
         build_exp(1'b0, v0, 1'b0, v1);
         press_btn();
         check_frame("t3");
         wait_idle("t3");
      end

      // Extra triggers while busy collapse into one pending sweep
      rdy_mode   = 2;
      ack_val[0] = 16'hCAFE;
      ack_val[1] = 16'h0F0F;
      ack_dly[0] = 1;
      ack_dly[1] = 1;
      build_exp(1'b0, 16'hCAFE, 1'b0, 16'h0F0F);
      press_btn();
      chk("t4_busy_a", int'(o_busy), 1);
      press_btn();
      press_btn();
      press_btn();
      chk("t4_busy_b", int'(o_busy), 1);
      chk("t4_sof_held", int'(o_tx_data), 8'hA5);
      rdy_mode = 0;
      check_frame("t4a");
      check_frame("t4b");
      wait_idle("t4");
      tick(100);
      chk("t4_no_third", rx_q.size(), 0);

      // Periodic sweeps every 100 cycles
      busy_rise_q.delete();
      ack_val[0] = 16'h1111;
      ack_val[1] = 16'h2222;
      build_exp(1'b0, 16'h1111, 1'b0, 16'h2222);
      i_auto_en = 1'b1;
      check_frame("t5a");
      check_frame("t5b");
      check_frame("t5c");
      i_auto_en = 1'b0;
      wait_idle("t5");
      chk("t5_sweeps", int'(busy_rise_q.size() >= 3), 1);
      chk("t5_period1", busy_rise_q[1] - busy_rise_q[0], 100);
      chk("t5_period2", busy_rise_q[2] - busy_rise_q[1], 100);
      chk("t5_req_lat", req_lat, 1);

      // Reset during the 4th byte of a frame
      rx_q.delete();
      ack_val[0] = 16'h1234;
      ack_val[1] = 16'hBEEF;
      i_user_btn = 1'b1;
      t = 0;
      while (rx_q.size() < 3 && t < 300) begin
         tick(1);
         t++;
      end
      chk("t6_three_sent", rx_q.size(), 3);
      @(negedge i_clk);
      #2;
      chk("t6_byte4", int'(o_tx_data), 8'h34);
      chk("t6_byte4_valid", int'(o_tx_valid), 1);
      i_rst = 1'b1;
      #1;
      chk("t6_rst_req", int'(o_req), 0);
      chk("t6_rst_valid", int'(o_tx_valid), 0);
      chk("t6_rst_data", int'(o_tx_data), 0);
      chk("t6_rst_busy", int'(o_busy), 0);
      chk("t6_rst_tocnt", int'(o_timeout_cnt), 0);
      #1;
      i_user_btn = 1'b0;
      tick(5);
      i_rst = 1'b0;
      rx_q.delete();
      tick(20);
      build_exp(1'b0, 16'h1234, 1'b0, 16'hBEEF);
      press_btn();
      check_frame("t6");
      wait_idle("t6");

      // 300 consecutive timeouts saturate the counter at 255
      ack_en[0] = 1'b0;
      ack_en[1] = 1'b0;
      build_exp(1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
      i_auto_en = 1'b1;
      for (int n = 1; n <= 150; n++) begin
         check_frame("t7");
         want = (2 * n > 255) ? 255 : 2 * n;
         chk("t7_tocnt", int'(o_timeout_cnt), want);
      end
      i_auto_en = 1'b0;
      wait_idle("t7");
      chk("t7_tocnt_final", int'(o_timeout_cnt), 255);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
